simd_activation_pipe: RTL and testbench
=======================================

// Module: simd_activation_pipe
// PURPOSE
// - Multi-lane fixed-point activation unit for the SIMD datapath; successor to the single-lane sigmoid.
// - LANES parallel two's-complement Q(BIT_WIDTH-DECIMAL_WIDTH).DECIMAL_WIDTH elements per beat.
// - Per-beat mode select: sigmoid, tanh, relu or pass.
// - valid/ready stream in and out, fixed 4-cycle pipeline with global stall, sticky clip flag.
// PARAMETERS
// - BIT_WIDTH      32  element width, two's complement
// - DECIMAL_WIDTH  16  fractional bits
// - LANES          4   parallel elements per beat
// PORTS
// - clk        in   1                clock, all logic on posedge
// - reset      in   1                synchronous, active-high
// - in_valid   in   1                input beat valid
// - in_ready   out  1                unit accepts beat this cycle
// - in_data    in   LANES*BIT_WIDTH  lane i at [i*BIT_WIDTH +: BIT_WIDTH]
// - in_mode    in   2                00 sigmoid, 01 tanh, 10 relu, 11 pass
// - out_valid  out  1                output beat valid
// - out_ready  in   1                downstream accepts
// - out_data   out  LANES*BIT_WIDTH  results, same lane packing
// - out_mode   out  2                mode of the beat on out_data
// - clip_flag  out  1                sticky: some accepted lane hit a clip region
// - clip_clear in   1                clears clip_flag
// BEHAVIOUR
// - Reset: all stage valids, out_valid, clip_flag = 0; out_data, out_mode = 0.
// - Advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
// - Accept: in_valid && in_ready.
// - All 4 stages shift together when adv = 1 and hold when adv = 0. Bubbles shift as invalid.
// - Latency: beat accepted at cycle N appears on out_data/out_valid at N+4 if never stalled.
// - out_data and out_mode hold while out_valid && !out_ready.
// - S1: per lane, sign = x[MSB]; a = |x|, with the most-negative value clamped to max positive.
//   - tanh: a = sat(2*a), clamped to max positive.
//   - clip = a >= 4.0 (4 << DECIMAL_WIDTH), valid in sigmoid and tanh only.
// - S2: sq = (a*a)[DECIMAL_WIDTH +: BIT_WIDTH]; lin = (0.25*a)[DECIMAL_WIDTH +: BIT_WIDTH].
//   - Full 2*BIT_WIDTH products; the square saturates to max positive if the upper bits are nonzero.
// - S3: s = 0.5 + lin - (0.03125*sq)[DECIMAL_WIDTH +: BIT_WIDTH]. If clip, s = 1.0.
// - S4, per mode:
//   - sigmoid: sign ? 1.0 - s : s.
//   - tanh: t = 2*s - 1.0; sign ? -t : t.
//   - relu: sign ? 0 : x.
//   - pass: x. The raw x is carried through the stages for relu and pass.
// - Truncation is floor (drop low bits); no rounding.
// - clip_flag, per cycle, on an accepted beat:
//   - Set if any lane clipped in S1.
//   - clip_clear && new clip event in the same cycle -> flag = 1 (set wins).
//   - clip_clear alone -> flag = 0.
// - Reset mid-operation: in-flight beats are discarded, no partial output. in_ready = 1 the cycle after reset drops.
// - Modes may change every beat; no per-beat dependency between lanes or beats.
// CONFIGURATION
// - ACT_LEAKY_RELU_EN defined: mode 10 is leaky relu; negative x -> x >>> 3 (arithmetic shift, slope 0.125).
// - ACT_LEAKY_RELU_EN undefined: mode 10 is plain relu; negative x -> 0.
// - Latency and ports are identical in both builds.
// TESTING (Q16.16, LANES=4)
// - Sigmoid lanes {0, 65536, -65536, 262144}, out_ready=1:
//   - out at +4 cycles = {32768, 47104, 18432, 65536}, clip_flag=1 next cycle.
// - Tanh lanes {0, 32768, -32768, 131072}:
//   - out = {0, 28672, -28672, 65536}, clip_flag sets.
// - Relu lanes {-65536, 65536, 0, 0x80000000}:
//   - out = {0, 65536, 0, 0}.
//   - With ACT_LEAKY_RELU_EN: {0xFFFFE000, 65536, 0, 0xF0000000}.
// - Back-to-back 8 beats, out_ready low cycles 3-6:
//   - in_ready falls with the stall, no beat lost or duplicated, order preserved, out_data stable while stalled.
// - Pass mode with 0x80000000 and max positive -> unchanged values.
//   - clip_flag: pulse clip_clear -> 0; clip_clear in the same cycle as a clipping beat -> stays 1.
// - Assert reset with 3 beats in flight -> no out_valid after reset, outputs 0, next accepted beat correct at +4.

Source files
------------

// File: rtl/simd_activation_pipe_if.sv
// Stream interface for simd_activation_pipe: input beat channel and output beat channel.
// The unit connects through the slave modport; the producer/consumer side uses master.
interface simd_activation_pipe_if #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned LANES     = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic [LANES*BIT_WIDTH-1:0]   in_data;
   logic [1:0]                   in_mode;
   logic                         out_valid;
   logic                         out_ready;
   logic [LANES*BIT_WIDTH-1:0]   out_data;
   logic [1:0]                   out_mode;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_mode
   );
endinterface

// File: rtl/simd_activation_pipe.sv
// Multi-lane fixed-point sigmoid/tanh/relu/pass unit, fixed 4-stage pipeline with global stall.
// Define ACT_LEAKY_RELU_EN to turn mode 10 into leaky relu (negative x -> x >>> 3).
module simd_activation_pipe #(
   parameter int unsigned BIT_WIDTH     = 32,
   parameter int unsigned DECIMAL_WIDTH = 16,
   parameter int unsigned LANES         = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   simd_activation_pipe_if.slave bus,
   input  logic                  clip_clear,
   output logic                  clip_flag
);
   typedef logic [BIT_WIDTH-1:0]   word_t;
   typedef logic [2*BIT_WIDTH-1:0] dword_t;
   typedef logic [LANES*BIT_WIDTH-1:0] beat_t;
   typedef enum logic [1:0] {ModeSigmoid = 2'b00, ModeTanh = 2'b01, ModeRelu = 2'b10,
                             ModePass = 2'b11} mode_e;

   localparam word_t MaxPos = {1'b0, {(BIT_WIDTH-1){1'b1}}};
   localparam word_t MinNeg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
   localparam word_t One    = word_t'(1) << DECIMAL_WIDTH;
   localparam word_t Half   = One >> 1;
   localparam word_t Four   = One << 2;

   logic adv, accept;
   logic v1_q, v2_q, v3_q, out_valid_q;
   mode_e mode1_q, mode2_q, mode3_q, out_mode_q;
   beat_t x1_q, x2_q, x3_q, out_data_q;
   logic [LANES-1:0] sign1_q, sign2_q, sign3_q, clip1_q, clip2_q;
   word_t [LANES-1:0] a1_q, sq2_q, lin2_q, s3_q;

   logic [LANES-1:0]  sign_d, clip_d;
   word_t [LANES-1:0] a_d, sq_d, lin_d, s_d;
   beat_t             out_d;
   mode_e             in_mode;

   assign adv          = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && adv;
   assign in_mode      = mode_e'(bus.in_mode);
   assign bus.in_ready = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data = out_data_q;
   assign bus.out_mode = out_mode_q;

   // S1: magnitude (most-negative clamped), tanh pre-doubling, clip detection.
   always_comb begin
      word_t x, a;
      x      = '0;
      a      = '0;
      a_d    = '0;
      sign_d = '0;
      clip_d = '0;
      for (int i = 0; i < LANES; i++) begin
         x = bus.in_data[i*BIT_WIDTH +: BIT_WIDTH];
         sign_d[i] = x[BIT_WIDTH-1];
         if (x == MinNeg)   a = MaxPos;
         else if (sign_d[i]) a = -x;
         else               a = x;
         if (in_mode == ModeTanh) a = a[BIT_WIDTH-2] ? MaxPos : (a << 1);
         a_d[i]    = a;
         clip_d[i] = (in_mode == ModeSigmoid || in_mode == ModeTanh) && (a >= Four);
      end
   end

   // S2: square (saturating) and quarter-slope term.
   always_comb begin
      dword_t prod;
      prod  = '0;
      sq_d  = '0;
      lin_d = '0;
      for (int i = 0; i < LANES; i++) begin
         prod     = dword_t'(a1_q[i]) * dword_t'(a1_q[i]);
         sq_d[i]  = ((prod >> (DECIMAL_WIDTH + BIT_WIDTH)) != '0) ? MaxPos
                                                                  : word_t'(prod >> DECIMAL_WIDTH);
         lin_d[i] = a1_q[i] >> 2;
      end
   end

   // S3: 0.5 + a/4 - a^2/32, forced to 1.0 in the clip region.
   always_comb begin
      s_d = '0;
      for (int i = 0; i < LANES; i++) begin
         s_d[i] = clip2_q[i] ? One : (Half + lin2_q[i] - (sq2_q[i] >> 5));
      end
   end

   // S4: fold the sign back in per mode.
   always_comb begin
      word_t x, t;
      x     = '0;
      t     = '0;
      out_d = '0;
      for (int i = 0; i < LANES; i++) begin
         x = x3_q[i*BIT_WIDTH +: BIT_WIDTH];
         t = (s3_q[i] << 1) - One;
         unique case (mode3_q)
            ModeSigmoid: out_d[i*BIT_WIDTH +: BIT_WIDTH] = sign3_q[i] ? (One - s3_q[i]) : s3_q[i];
            ModeTanh:    out_d[i*BIT_WIDTH +: BIT_WIDTH] = sign3_q[i] ? -t : t;
`ifdef ACT_LEAKY_RELU_EN
            ModeRelu:    out_d[i*BIT_WIDTH +: BIT_WIDTH] = sign3_q[i] ? word_t'($signed(x) >>> 3)
                                                                      : x;
`else
            ModeRelu:    out_d[i*BIT_WIDTH +: BIT_WIDTH] = sign3_q[i] ? '0 : x;
`endif
            ModePass:    out_d[i*BIT_WIDTH +: BIT_WIDTH] = x;
            default:     out_d[i*BIT_WIDTH +: BIT_WIDTH] = x;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
         mode1_q     <= ModeSigmoid;
         mode2_q     <= ModeSigmoid;
         mode3_q     <= ModeSigmoid;
         out_mode_q  <= ModeSigmoid;
         x1_q        <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
         out_data_q  <= '0;
         sign1_q     <= '0;
         sign2_q     <= '0;
         sign3_q     <= '0;
         clip1_q     <= '0;
         clip2_q     <= '0;
         a1_q        <= '0;
         sq2_q       <= '0;
         lin2_q      <= '0;
         s3_q        <= '0;
      end else if (adv) begin
         v1_q        <= bus.in_valid;
         mode1_q     <= in_mode;
         x1_q        <= bus.in_data;
         sign1_q     <= sign_d;
         clip1_q     <= clip_d;
         a1_q        <= a_d;
         v2_q        <= v1_q;
         mode2_q     <= mode1_q;
         x2_q        <= x1_q;
         sign2_q     <= sign1_q;
         clip2_q     <= clip1_q;
         sq2_q       <= sq_d;
         lin2_q      <= lin_d;
         v3_q        <= v2_q;
         mode3_q     <= mode2_q;
         x3_q        <= x2_q;
         sign3_q     <= sign2_q;
         s3_q        <= s_d;
         out_valid_q <= v3_q;
         out_mode_q  <= mode3_q;
         out_data_q  <= out_d;
      end
   end

   // Set wins over clear when both happen in the same cycle.
   always_ff @(posedge clk) begin
      if (reset)                     clip_flag <= 1'b0;
      else if (accept && |clip_d)    clip_flag <= 1'b1;
      else if (clip_clear)           clip_flag <= 1'b0;
   end
endmodule

// File: tb/tb_simd_activation_pipe.sv
// Directed, table-driven bench for simd_activation_pipe (Q16.16, 4 lanes), plus stall,
// clip-flag and mid-flight reset sequences.
module tb_simd_activation_pipe;
   typedef struct {
      logic [1:0]   mode;
      logic [127:0] din;
      logic [127:0] dout;
      logic         clip;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic clip_clear;
   logic clip_flag;
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t vecs[7];

   simd_activation_pipe_if #(.BIT_WIDTH(32), .LANES(4)) bus ();

   simd_activation_pipe #(
      .BIT_WIDTH(32),
      .DECIMAL_WIDTH(16),
      .LANES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .clip_clear(clip_clear),
      .clip_flag(clip_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic [1:0] m,
                               input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] i2, input logic [31:0] i3,
                               input logic [31:0] o0, input logic [31:0] o1,
                               input logic [31:0] o2, input logic [31:0] o3,
                               input logic c);
      vec_t v;
      v.mode = m;
      v.din  = {i3, i2, i1, i0};
      v.dout = {o3, o2, o1, o0};
      v.clip = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for a single cycle (out_ready is high, so in_ready is high).
   task automatic send(input logic [1:0] m, input logic [127:0] d, input logic clr);
      bus.in_valid = 1'b1;
      bus.in_mode  = m;
      bus.in_data  = d;
      clip_clear   = clr;
      tick();
      bus.in_valid = 1'b0;
      clip_clear   = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      clip_clear = 1'b1;
      tick();
      clip_clear = 1'b0;
      check({tag, "_clip_cleared"}, 128'(clip_flag), 128'(1'b0));
      send(v.mode, v.din, 1'b0);
      check({tag, "_clip_flag"}, 128'(clip_flag), 128'(v.clip));
      tick();
      tick();
      check({tag, "_early_valid"}, 128'(bus.out_valid), 128'(1'b0));
      tick();
      check({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
      check({tag, "_data"}, bus.out_data, v.dout);
      check({tag, "_mode"}, 128'(bus.out_mode), 128'(v.mode));
   endtask

   function automatic logic [127:0] beat_data(input int k);
      logic [127:0] d;
      for (int j = 0; j < 4; j++) d[j*32 +: 32] = 32'(k * 16 + j + 1);
      return d;
   endfunction

   initial begin
      vecs[0] = mk(2'b00, 32'd0, 32'd65536, 32'hFFFF0000, 32'd262144,
                   32'd32768, 32'd47104, 32'd18432, 32'd65536, 1'b1);
      vecs[1] = mk(2'b01, 32'd0, 32'd32768, 32'hFFFF8000, 32'd131072,
                   32'd0, 32'd28672, 32'hFFFF9000, 32'd65536, 1'b1);
`ifdef ACT_LEAKY_RELU_EN
      vecs[2] = mk(2'b10, 32'hFFFF0000, 32'd65536, 32'd0, 32'h80000000,
                   32'hFFFFE000, 32'd65536, 32'd0, 32'hF0000000, 1'b0);
`else
      vecs[2] = mk(2'b10, 32'hFFFF0000, 32'd65536, 32'd0, 32'h80000000,
                   32'd0, 32'd65536, 32'd0, 32'd0, 1'b0);
`endif
      vecs[3] = mk(2'b11, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF,
                   32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 1'b0);
      vecs[4] = mk(2'b00, 32'd32768, 32'hFFFF8000, 32'd131072, 32'h80000000,
                   32'd40448, 32'd25088, 32'd57344, 32'd0, 1'b1);
      vecs[5] = mk(2'b01, 32'd16384, 32'hFFFFC000, 32'd65536, 32'h80000000,
                   32'd15360, 32'hFFFFC400, 32'd49152, 32'hFFFF0000, 1'b1);
      vecs[6] = mk(2'b00, 32'd262143, 32'hFFFC0001, 32'd1, 32'hFFFFFFFF,
                   32'd65536, 32'd0, 32'd32768, 32'd32768, 1'b0);

      reset         = 1'b1;
      clip_clear    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 2'b00;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("rst_out_data", bus.out_data, 128'd0);
      check("rst_out_mode", 128'(bus.out_mode), 128'd0);
      check("rst_clip_flag", 128'(clip_flag), 128'(1'b0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));

      for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

      // Back-to-back 8 beats with out_ready low in cycles 3..6.
      begin
         logic [127:0] held;
         logic         stalled_prev;
         logic         acc, took;
         int           sent, rcv;
         sent = 0;
         rcv = 0;
         stalled_prev = 1'b0;
         held = '0;
         tick();
         for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent == 8 && rcv == 8) break;
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (sent < 8);
            bus.in_data   = beat_data(sent);
            bus.in_mode   = sent[0] ? 2'b10 : 2'b11;
            #1;
            check("stall_in_ready", 128'(bus.in_ready),
                  128'(!(bus.out_valid && !bus.out_ready)));
            if (stalled_prev) check("stall_hold", bus.out_data, held);
            acc  = bus.in_valid && bus.in_ready;
            took = bus.out_valid && bus.out_ready;
            if (took) begin
               if (rcv < 8) begin
                  check($sformatf("stall_beat%0d_data", rcv), bus.out_data, beat_data(rcv));
                  check($sformatf("stall_beat%0d_mode", rcv), 128'(bus.out_mode),
                        128'(rcv[0] ? 2'b10 : 2'b11));
               end else begin
                  check("stall_extra_beat", 128'(rcv), 128'd7);
               end
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            tick();
            if (acc) sent++;
            if (took) rcv++;
         end
         check("stall_sent", 128'(sent), 128'd8);
         check("stall_rcvd", 128'(rcv), 128'd8);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         repeat (5) tick();
      end

      // Clip flag: clear alone, clear with non-clipping beat, clear with clipping beat.
      send(2'b00, vecs[0].din, 1'b0);
      check("clip_set", 128'(clip_flag), 128'(1'b1));
      clip_clear = 1'b1;
      tick();
      clip_clear = 1'b0;
      check("clip_clear_alone", 128'(clip_flag), 128'(1'b0));
      send(2'b00, vecs[0].din, 1'b1);
      check("clip_set_wins", 128'(clip_flag), 128'(1'b1));
      send(2'b00, vecs[6].din, 1'b1);
      check("clip_clear_noclip_beat", 128'(clip_flag), 128'(1'b0));
      send(2'b10, vecs[2].din, 1'b0);
      check("clip_relu_no_set", 128'(clip_flag), 128'(1'b0));
      repeat (5) tick();

      // Reset with three beats in flight, one of them already on the output.
      send(2'b01, vecs[1].din, 1'b0);
      send(2'b01, vecs[1].din, 1'b0);
      send(2'b01, vecs[1].din, 1'b0);
      tick();
      check("inflight_out_valid", 128'(bus.out_valid), 128'(1'b1));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("midrst_out_data", bus.out_data, 128'd0);
      check("midrst_out_mode", 128'(bus.out_mode), 128'd0);
      check("midrst_clip_flag", 128'(clip_flag), 128'(1'b0));
      check("midrst_in_ready", 128'(bus.in_ready), 128'(1'b1));
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.out_valid) seen++;
         end
         check("midrst_no_output", 128'(seen), 128'd0);
      end
      run_vec(vecs[1], "postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
